// File: rtl/rgb_line_buffer.sv
// rgb_line_buffer: 24-bit RGB pixel FIFO with a registered FWFT valid/ready output.
// Define LINE_CHECK_EN to build the per-line pixel length checker driving line_err.
module rgb_line_buffer #(
  parameter int DATA_W      = 24,
  parameter int FIFO_DEPTH  = 64,
  parameter int LINE_PIXELS = 1920
) (
  input  logic                        clk_300m,
  input  logic                        reset_n,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        data_in_last,
  input  logic                        data_en,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_out_last,
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        line_err,
  output logic [15:0]                 line_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

  typedef enum logic {
    S_EMPTY,
    S_VALID
  } state_t;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       level_q;
  logic [AW:0]       level_d;
  logic              ne_q;
  state_t            state_q;
  state_t            state_d;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] dout_q;
  logic              dlast_q;
  logic              ovf_q;
  logic [15:0]       lcnt_q;

  assign push = data_en && (level_q != FULL);

  // Pixel storage; no reset needed, occupancy is tracked by level_q.
  always_ff @(posedge clk_300m) begin
    if (push) begin
      mem[wr_ptr_q] <= {data_in_last, data_in};
    end
  end

  // Occupancy next state from push/pop of this cycle.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointers, level, and a registered not-empty flag that paces wake-up.
  always_ff @(posedge clk_300m or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ne_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ne_q    <= (level_q != '0);
    end
  end

  // Output FSM next state; a pop always loads the output register.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (ne_q) begin
          pop     = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (data_out_ready) begin
          if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Output FSM state register.
  always_ff @(posedge clk_300m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output word register, held until the sink accepts it.
  always_ff @(posedge clk_300m or negedge reset_n) begin
    if (!reset_n) begin
      dout_q  <= '0;
      dlast_q <= 1'b0;
    end else if (pop) begin
      {dlast_q, dout_q} <= mem[rd_ptr_q];
    end
  end

  // Sticky overflow and completed-line counter.
  always_ff @(posedge clk_300m or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q  <= 1'b0;
      lcnt_q <= '0;
    end else begin
      if (data_en && !push) ovf_q <= 1'b1;
      if ((state_q == S_VALID) && data_out_ready && dlast_q) begin
        lcnt_q <= lcnt_q + 16'd1;
      end
    end
  end

`ifdef LINE_CHECK_EN
  localparam logic [16:0] LP = LINE_PIXELS[16:0];

  logic [15:0] pix_q;
  logic [16:0] pix_inc;
  logic        err_q;

  assign pix_inc = {1'b0, pix_q} + 17'd1;

  // Count accepted pixels per line; flag short, long or runaway lines.
  always_ff @(posedge clk_300m or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= '0;
      err_q <= 1'b0;
    end else if (push) begin
      if (data_in_last) begin
        if (pix_inc != LP) err_q <= 1'b1;
        pix_q <= '0;
      end else if ({1'b0, pix_q} != LP + 17'd1) begin
        pix_q <= pix_inc[15:0];
        if (pix_inc == LP + 17'd1) err_q <= 1'b1;
      end
    end
  end

  assign line_err = err_q;
`else
  assign line_err = 1'b0;
`endif

  assign data_out       = dout_q;
  assign data_out_last  = dlast_q;
  assign data_out_valid = (state_q == S_VALID);
  assign fifo_level     = level_q;
  assign overflow       = ovf_q;
  assign line_cnt       = lcnt_q;

endmodule

// File: tb/tb_rgb_line_buffer.sv
// tb_rgb_line_buffer: scoreboard bench for rgb_line_buffer.
// Expected words are queued at write time; a monitor pops on each handshake.
module tb_rgb_line_buffer;
  localparam int DW    = 24;
  localparam int DEPTH = 64;
  localparam int LP    = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] data_in;
  logic          data_in_last;
  logic          data_en;
  logic [DW-1:0] data_out;
  logic          data_out_last;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [6:0]    fifo_level;
  logic          overflow;
  logic          line_err;
  logic [15:0]   line_cnt;

  rgb_line_buffer #(
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH),
    .LINE_PIXELS (LP)
  ) dut (
    .clk_300m       (clk),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .data_in_last   (data_in_last),
    .data_en        (data_en),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .line_err       (line_err),
    .line_cnt       (line_cnt)
  );

  always #5 clk = ~clk;

  logic [DW:0] exp_q [$];
  int          checks    = 0;
  int          errors    = 0;
  int          exp_lines = 0;
  int          popped    = 0;
  int          run       = 0;
  int          max_run   = 0;
  bit          model_err = 1'b0;
  bit          prev_hold = 1'b0;
  logic [DW:0] prev_word = '0;
  bit          rnd_done;
`ifdef LINE_CHECK_EN
  int          model_cnt = 0;
`endif

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: every accepted word leaves in order; line length rule.
  task automatic model_accept(input logic [DW-1:0] p, input bit l);
    exp_q.push_back({l, p});
`ifdef LINE_CHECK_EN
    if (l) begin
      if (model_cnt + 1 != LP) model_err = 1'b1;
      model_cnt = 0;
    end else if (model_cnt < LP + 1) begin
      model_cnt++;
      if (model_cnt == LP + 1) model_err = 1'b1;
    end
`endif
  endtask

  task automatic wr(input logic [DW-1:0] p, input bit l, input bit acc);
    data_in      = p;
    data_in_last = l;
    data_en      = 1'b1;
    if (acc) model_accept(p, l);
    @(posedge clk);
    #1;
    data_en      = 1'b0;
    data_in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    data_en = 1'b0;
    exp_q.delete();
    exp_lines = 0;
    model_err = 1'b0;
`ifdef LINE_CHECK_EN
    model_cnt = 0;
`endif
    @(negedge clk);
    chk("rst_valid", 64'(data_out_valid), 64'd0);
    chk("rst_data", 64'({data_out_last, data_out}), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_lerr", 64'(line_err), 64'd0);
    chk("rst_lcnt", 64'(line_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=0 words left",
               name, exp_q.size());
      exp_q.delete();
    end
    idle(3);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold stability.
  always @(negedge clk) begin
    logic [DW:0] w;
    if (!reset_n) begin
      prev_hold = 1'b0;
      run       = 0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (!data_out_valid || {data_out_last, data_out} !== prev_word) begin
          errors++;
          $display("FAIL hold actual=%0h/%0b required=%0h/1",
                   {data_out_last, data_out}, data_out_valid, prev_word);
        end
      end
      if (data_out_valid && data_out_ready) begin
        run++;
        if (run > max_run) max_run = run;
        popped++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop actual=%0h required=nothing",
                   {data_out_last, data_out});
        end else begin
          w = exp_q.pop_front();
          if (w[DW]) exp_lines++;
          if ({data_out_last, data_out} !== w) begin
            errors++;
            $display("FAIL pop actual=%0h required=%0h",
                     {data_out_last, data_out}, w);
          end
        end
      end else begin
        run = 0;
      end
      prev_hold = data_out_valid && !data_out_ready;
      prev_word = {data_out_last, data_out};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    data_in        = '0;
    data_in_last   = 1'b0;
    data_en        = 1'b0;
    data_out_ready = 1'b0;
    idle(2);
    do_reset();

    // Reset mid-stream discards buffered words.
    for (int i = 0; i < 5; i++) wr(DW'($urandom), 1'b0, 1'b1);
    idle(2);
    do_reset();

    // Two-edge latency from write to valid.
    wr(24'hABCDEF, 1'b0, 1'b1);
    chk("lat_n0", 64'(data_out_valid), 64'd0);
    idle(1);
    chk("lat_n1", 64'(data_out_valid), 64'd0);
    idle(1);
    chk("lat_n2", 64'(data_out_valid), 64'd1);
    chk("lat_data", 64'(data_out), 64'hABCDEF);
    data_out_ready = 1'b1;
    wait_drain("lat", 50);
    do_reset();

    // Back-to-back line with ready held high.
    data_out_ready = 1'b1;
    max_run = 0;
    for (int i = 1; i <= LP; i++) wr(DW'(i), (i == LP), 1'b1);
    wait_drain("b2b", 50);
    chk("b2b_run", 64'(max_run), 64'(LP));
    chk("b2b_lcnt", 64'(line_cnt), 64'(exp_lines));
    chk("b2b_lcnt1", 64'(exp_lines), 64'd1);
    chk("b2b_lerr", 64'(line_err), 64'(model_err));

    // Random gaps and random ready over ten lines.
    rnd_done = 1'b0;
    fork
      begin
        for (int ln = 0; ln < 10; ln++) begin
          for (int i = 0; i < LP; i++) begin
            while ($urandom_range(2) != 0) idle(1);
            wr(DW'($urandom), (i == LP - 1), 1'b1);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          data_out_ready = $urandom_range(1) == 1;
        end
      end
    join
    data_out_ready = 1'b1;
    wait_drain("rnd", 500);
    chk("rnd_lcnt", 64'(line_cnt), 64'(exp_lines));
    chk("rnd_ovf", 64'(overflow), 64'd0);
    chk("rnd_lerr", 64'(line_err), 64'(model_err));

    // Short line with last, then a long line without last.
    do_reset();
    data_out_ready = 1'b1;
    for (int i = 1; i <= LP - 1; i++) wr(DW'(i), (i == LP - 1), 1'b1);
    wait_drain("short", 50);
    chk("short_lerr", 64'(line_err), 64'(model_err));
    chk("short_lcnt", 64'(line_cnt), 64'(exp_lines));
    do_reset();
    data_out_ready = 1'b1;
    for (int i = 1; i <= LP + 1; i++) wr(DW'(i), 1'b0, 1'b1);
    wait_drain("long", 50);
    chk("long_lerr", 64'(line_err), 64'(model_err));
    chk("long_lcnt", 64'(line_cnt), 64'd0);

    // Backpressure: capacity is DEPTH in FIFO plus the output register.
    do_reset();
    data_out_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      wr(DW'(i), 1'b0, (i <= DEPTH + 1));
      if (i == DEPTH + 1) chk("bp_ovf_pre", 64'(overflow), 64'd0);
    end
    idle(1);
    chk("bp_head", 64'(data_out), 64'd1);
    chk("bp_valid", 64'(data_out_valid), 64'd1);
    chk("bp_level", 64'(fifo_level), 64'(DEPTH));
    chk("bp_ovf", 64'(overflow), 64'd1);
    popped = 0;
    data_out_ready = 1'b1;
    wait_drain("bp", 300);
    chk("bp_count", 64'(popped), 64'(DEPTH + 1));
    chk("bp_level_end", 64'(fifo_level), 64'd0);

    // Push and pop together while full: the push is dropped.
    do_reset();
    data_out_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) wr(DW'(32'h100 + i), 1'b0, 1'b1);
    idle(2);
    chk("sim_ovf_pre", 64'(overflow), 64'd0);
    chk("sim_level_pre", 64'(fifo_level), 64'(DEPTH));
    data_in        = 24'h00DEAD;
    data_en        = 1'b1;
    data_out_ready = 1'b1;
    idle(1);
    data_en        = 1'b0;
    data_out_ready = 1'b0;
    chk("sim_level", 64'(fifo_level), 64'(DEPTH - 1));
    chk("sim_ovf", 64'(overflow), 64'd1);
    popped = 0;
    data_out_ready = 1'b1;
    wait_drain("sim", 300);
    chk("sim_count", 64'(popped), 64'(DEPTH));
    chk("end_level", 64'(fifo_level), 64'd0);
    chk("end_valid", 64'(data_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
